f_spsram_ctrl: RTL and testbench

F_SPSRAM_CTRL -- requirements
Module: f_spsram_ctrl

---
 rtl/f_spsram_ctrl.sv | 130 +++++++++++++
 tb/tb_f_spsram_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
// f_spsram_ctrl : two-requester round-robin front end and zero-fill sequencer
//                 for a single-port SRAM.  Revision 1.0
// ============================================================================
module f_spsram_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int INIT_EN    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req0_vld,
  output logic                    req0_rdy,
  input  logic                    req0_wr,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_be,
  input  logic                    req1_vld,
  output logic                    req1_rdy,
  input  logic                    req1_wr,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_be,
  output logic                    rsp0_vld,
  output logic                    rsp1_vld,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   mem_A,
  output logic                    mem_CEN,
  output logic [DATA_WIDTH-1:0]   mem_D,
  output logic [DATA_WIDTH/8-1:0] mem_WEN,
  input  logic [DATA_WIDTH-1:0]   mem_Q
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    rsp0_vld_q, rsp0_vld_d;
  logic                    rsp1_vld_q, rsp1_vld_d;
  logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0]   mem_d_q, mem_d_d;
  logic [DATA_WIDTH/8-1:0] mem_wen_q, mem_wen_d;
  logic                    run;
  logic                    acc0, acc1;

  // On a conflict the requester that was not served last wins.
  always_comb begin
    run      = (state_q == ST_RUN) && !RST;
    req0_rdy = run && req0_vld && (!req1_vld || last_q);
    req1_rdy = run && req1_vld && (!req0_vld || !last_q);
    acc0     = req0_vld && req0_rdy;
    acc1     = req1_vld && req1_rdy;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    rsp0_vld_d = 1'b0;
    rsp1_vld_d = 1'b0;
    mem_CEN    = 1'b1;
    mem_A      = mem_a_q;
    mem_D      = mem_d_q;
    mem_WEN    = mem_wen_q;
    if (!RST && state_q == ST_INIT) begin
      mem_CEN = 1'b0;
      mem_A   = cnt_q;
      mem_D   = '0;
      mem_WEN = '0;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end else if (acc0 || acc1) begin
      mem_CEN    = 1'b0;
      mem_A      = acc1 ? req1_addr  : req0_addr;
      mem_D      = acc1 ? req1_wdata : req0_wdata;
      if (acc1) begin
        mem_WEN = req1_wr ? ~req1_be : '1;
      end else begin
        mem_WEN = req0_wr ? ~req0_be : '1;
      end
      last_d     = acc1;
      rsp0_vld_d = acc0 && !req0_wr;
      rsp1_vld_d = acc1 && !req1_wr;
    end
  end

  // Idle cycles keep the SRAM pins at whatever was last driven.
  assign mem_a_d   = mem_A;
  assign mem_d_d   = mem_D;
  assign mem_wen_d = mem_WEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      mem_wen_q  <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      mem_wen_q  <= mem_wen_d;
    end
  end

  assign rsp0_vld  = rsp0_vld_q;
  assign rsp1_vld  = rsp1_vld_q;
  assign rsp_rdata = mem_Q;
  assign init_done = (state_q == ST_RUN) && !RST;

endmodule
`default_nettype wire

// File: tb/tb_f_spsram_ctrl.sv
`default_nettype none
// tb_f_spsram_ctrl : directed and randomized checks of f_spsram_ctrl against a
// word-level memory model and a round-robin grant model.
module tb_f_spsram_ctrl;
  localparam int AW     = 15;
  localparam int DW     = 128;
  localparam int BW     = DW / 8;
  localparam int AWB    = 4;
  localparam int NWORDS = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A: INIT_EN=1, full 32K-word memory ------------
  logic          rst = 1'b1;
  logic [1:0]    vld = '0;
  logic [1:0]    wr  = '0;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [BW-1:0] be    [2];
  logic          rdy0, rdy1, rspv0, rspv1, init_done, mem_cen;
  logic [DW-1:0] rdata, mem_d, mem_q;
  logic [AW-1:0] mem_a;
  logic [BW-1:0] mem_wen;

  f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) u_dut (
    .CLK(clk), .RST(rst),
    .req0_vld(vld[0]), .req0_rdy(rdy0), .req0_wr(wr[0]), .req0_addr(addr[0]),
    .req0_wdata(wdata[0]), .req0_be(be[0]),
    .req1_vld(vld[1]), .req1_rdy(rdy1), .req1_wr(wr[1]), .req1_addr(addr[1]),
    .req1_wdata(wdata[1]), .req1_be(be[1]),
    .rsp0_vld(rspv0), .rsp1_vld(rspv1), .rsp_rdata(rdata), .init_done(init_done),
    .mem_A(mem_a), .mem_CEN(mem_cen), .mem_D(mem_d), .mem_WEN(mem_wen), .mem_Q(mem_q)
  );

  logic [DW-1:0] sram_a [NWORDS];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (&mem_wen) mem_q <= sram_a[mem_a];
      for (int i = 0; i < BW; i++)
        if (!mem_wen[i]) sram_a[mem_a][i*8 +: 8] <= mem_d[i*8 +: 8];
    end
  end

  // ---------------- instance B: INIT_EN=0, small memory --------------------
  logic           b_rst = 1'b1;
  logic [1:0]     b_vld = '0;
  logic [1:0]     b_wr  = '0;
  logic [AWB-1:0] b_addr [2];
  logic [DW-1:0]  b_wdata [2];
  logic [BW-1:0]  b_be [2];
  logic           b_rdy0, b_rdy1, b_rspv0, b_rspv1, b_init_done, b_cen;
  logic [DW-1:0]  b_rdata, b_mem_d, b_mem_q;
  logic [AWB-1:0] b_mem_a;
  logic [BW-1:0]  b_wen;

  f_spsram_ctrl #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW), .INIT_EN(0)) u_dut_b (
    .CLK(clk), .RST(b_rst),
    .req0_vld(b_vld[0]), .req0_rdy(b_rdy0), .req0_wr(b_wr[0]), .req0_addr(b_addr[0]),
    .req0_wdata(b_wdata[0]), .req0_be(b_be[0]),
    .req1_vld(b_vld[1]), .req1_rdy(b_rdy1), .req1_wr(b_wr[1]), .req1_addr(b_addr[1]),
    .req1_wdata(b_wdata[1]), .req1_be(b_be[1]),
    .rsp0_vld(b_rspv0), .rsp1_vld(b_rspv1), .rsp_rdata(b_rdata), .init_done(b_init_done),
    .mem_A(b_mem_a), .mem_CEN(b_cen), .mem_D(b_mem_d), .mem_WEN(b_wen), .mem_Q(b_mem_q)
  );

  logic [DW-1:0] sram_b [1 << AWB];
  always @(posedge clk) begin
    if (!b_cen) begin
      if (&b_wen) b_mem_q <= sram_b[b_mem_a];
      for (int i = 0; i < BW; i++)
        if (!b_wen[i]) sram_b[b_mem_a][i*8 +: 8] <= b_mem_d[i*8 +: 8];
    end
  end

  function automatic logic [DW-1:0] b_preload(input int i);
    return {4{32'(i) ^ 32'hA5A5_0000}};
  endfunction

  // ---------------- reference model ----------------------------------------
  logic [DW-1:0] ref_mem [int];
  int            m_last    = 1;
  logic [1:0]    exp_rspv  = '0;
  logic [DW-1:0] exp_rdata = '0;

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic void ref_wr(input int a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    logic [DW-1:0] v;
    v = ref_rd(a);
    for (int i = 0; i < BW; i++)
      if (b[i]) v[i*8 +: 8] = d[i*8 +: 8];
    ref_mem[a] = v;
  endfunction

  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset;
    rst = 1'b1; vld = 2'b11; wr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (mem_cen !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b expected 1", mem_cen); end
    checks++;
    if ({rdy1, rdy0} !== 2'b00) begin errors++; $display("FAIL reset_rdy: got %b expected 00", {rdy1, rdy0}); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++;
    if ({rspv1, rspv0} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b expected 00", {rspv1, rspv0}); end
    @(posedge clk); #1;
  endtask

  task automatic test_init_abort;
    int bad_seq = 0;
    int bad_quiet = 0;
    rst = 1'b0;
    for (int n = 0; n < NWORDS / 2; n++) begin
      @(negedge clk);
      if (mem_cen !== 1'b0 || mem_a !== AW'(n) || mem_wen !== '0 || mem_d !== '0) bad_seq++;
      if ({rdy1, rdy0, rspv1, rspv0, init_done} !== 5'b0) bad_quiet++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_seq != 0) begin errors++; $display("FAIL abort_fill_seq: got %0d bad cycles expected 0", bad_seq); end
    checks++;
    if (bad_quiet != 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad_quiet); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_cen !== 1'b1 || {rdy1, rdy0} !== 2'b00)
      begin errors++; $display("FAIL abort_rst_cycle: got cen=%b rdy=%b expected cen=1 rdy=00", mem_cen, {rdy1, rdy0}); end
    @(posedge clk); #1;
    vld = 2'b00;
  endtask

  task automatic test_init_full;
    int bad_seq = 0;
    int bad_done = 0;
    rst = 1'b0; m_last = 1; exp_rspv = '0;
    for (int n = 0; n < NWORDS; n++) begin
      @(negedge clk);
      if (mem_cen !== 1'b0 || mem_a !== AW'(n) || mem_wen !== '0 || mem_d !== '0) bad_seq++;
      if (init_done !== 1'b0) bad_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_seq != 0) begin errors++; $display("FAIL fill_seq: got %0d bad cycles expected 0", bad_seq); end
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL fill_early_done: got %0d cycles expected 0", bad_done); end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL fill_done: got %b expected 1", init_done); end
    checks++;
    if (mem_cen !== 1'b1) begin errors++; $display("FAIL run_idle_cen: got %b expected 1", mem_cen); end
    @(posedge clk); #1;
  endtask

  task automatic test_alternate;
    int g;
    int prev_g = -1;
    vld = 2'b11; wr = 2'b00;
    addr[0] = AW'(100); addr[1] = AW'(200);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = pick(1'b1, 1'b1);
      checks++;
      if ({rdy1, rdy0} !== 2'(1 << g)) begin errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", k, {rdy1, rdy0}, 2'(1 << g)); end
      checks++;
      if (mem_cen !== 1'b0 || mem_a !== addr[g] || mem_wen !== {BW{1'b1}})
        begin errors++; $display("FAIL alt_mem[%0d]: got cen=%b a=%0h wen=%h expected cen=0 a=%0h wen=ffff", k, mem_cen, mem_a, mem_wen, addr[g]); end
      if (prev_g >= 0) begin
        checks++;
        if ({rspv1, rspv0} !== 2'(1 << prev_g) || rdata !== ref_rd(int'(addr[prev_g])))
          begin errors++; $display("FAIL alt_rsp[%0d]: got vld=%b data=%h expected vld=%b data=%h", k, {rspv1, rspv0}, rdata, 2'(1 << prev_g), ref_rd(int'(addr[prev_g]))); end
      end
      m_last = g; prev_g = g;
      @(posedge clk); #1;
    end
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({rspv1, rspv0} !== 2'(1 << prev_g)) begin errors++; $display("FAIL alt_last_rsp: got %b expected %b", {rspv1, rspv0}, 2'(1 << prev_g)); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_merge;
    vld = 2'b01; wr[0] = 1'b1; addr[0] = AW'(5); wdata[0] = '1; be[0] = 16'h0001;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || mem_cen !== 1'b0 || mem_a !== AW'(5) || mem_wen !== 16'hFFFE || mem_d !== wdata[0])
      begin errors++; $display("FAIL bm_write: got rdy=%b cen=%b a=%0h wen=%h expected rdy=1 cen=0 a=5 wen=fffe", rdy0, mem_cen, mem_a, mem_wen); end
    ref_wr(5, wdata[0], be[0]); m_last = 0;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || mem_cen !== 1'b0 || mem_wen !== {BW{1'b1}})
      begin errors++; $display("FAIL bm_read: got rdy=%b cen=%b wen=%h expected rdy=1 cen=0 wen=ffff", rdy0, mem_cen, mem_wen); end
    @(posedge clk); #1;
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({rspv1, rspv0} !== 2'b01) begin errors++; $display("FAIL bm_rsp_vld: got %b expected 01", {rspv1, rspv0}); end
    checks++;
    if (rdata !== ref_rd(5)) begin errors++; $display("FAIL bm_rdata: got %h expected %h", rdata, ref_rd(5)); end
    checks++;
    if (mem_cen !== 1'b1 || mem_a !== AW'(5) || mem_wen !== {BW{1'b1}} || mem_d !== wdata[0])
      begin errors++; $display("FAIL idle_hold: got cen=%b a=%0h wen=%h expected cen=1 a=5 wen=ffff", mem_cen, mem_a, mem_wen); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rspv1, rspv0} !== 2'b00) begin errors++; $display("FAIL bm_rsp_pulse: got %b expected 00", {rspv1, rspv0}); end
    @(posedge clk); #1;
  endtask

  task automatic test_be_zero;
    vld = 2'b10; wr[1] = 1'b1; addr[1] = AW'(7); wdata[1] = DW'(16'h1234); be[1] = '1;
    @(negedge clk);
    ref_wr(7, wdata[1], be[1]); m_last = 1;
    @(posedge clk); #1;
    wdata[1] = {4{32'hDEAD_BEEF}}; be[1] = '0;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1 || mem_cen !== 1'b0 || mem_wen !== 16'hFFFF)
      begin errors++; $display("FAIL bez_write: got rdy=%b cen=%b wen=%h expected rdy=1 cen=0 wen=ffff", rdy1, mem_cen, mem_wen); end
    ref_wr(7, wdata[1], be[1]);
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({rspv1, rspv0} !== 2'b10 || rdata !== ref_rd(7))
      begin errors++; $display("FAIL bez_read: got vld=%b data=%h expected vld=10 data=%h", {rspv1, rspv0}, rdata, ref_rd(7)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    bit pend [2];
    int g;
    pend[0] = 1'b0; pend[1] = 1'b0; exp_rspv = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(2) != 0) begin
          pend[n]  = 1'b1;
          wr[n]    = 1'($urandom_range(1));
          addr[n]  = ($urandom_range(7) == 0) ? AW'(NWORDS - 1) : AW'($urandom_range(15));
          wdata[n] = {$urandom, $urandom, $urandom, $urandom};
          be[n]    = ($urandom_range(5) == 0) ? '0 : BW'($urandom);
        end
        vld[n] = pend[n];
      end
      @(negedge clk);
      g = pick(vld[0], vld[1]);
      checks++;
      if ({rdy1, rdy0} !== ((g < 0) ? 2'b00 : 2'(1 << g)))
        begin errors++; $display("FAIL rnd_grant[%0d]: got %b expected %b", cyc, {rdy1, rdy0}, (g < 0) ? 2'b00 : 2'(1 << g)); end
      checks++;
      if ({rspv1, rspv0} !== exp_rspv) begin errors++; $display("FAIL rnd_rsp_vld[%0d]: got %b expected %b", cyc, {rspv1, rspv0}, exp_rspv); end
      if (exp_rspv != 2'b00) begin
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", cyc, rdata, exp_rdata); end
      end
      checks++;
      if (g >= 0) begin
        if (mem_cen !== 1'b0 || mem_a !== addr[g] || mem_wen !== (wr[g] ? ~be[g] : {BW{1'b1}}) || (wr[g] && mem_d !== wdata[g]))
          begin errors++; $display("FAIL rnd_mem[%0d]: got cen=%b a=%0h wen=%h expected cen=0 a=%0h wen=%h", cyc, mem_cen, mem_a, mem_wen, addr[g], wr[g] ? ~be[g] : {BW{1'b1}}); end
        if (wr[g]) begin
          ref_wr(int'(addr[g]), wdata[g], be[g]);
          exp_rspv = 2'b00;
        end else begin
          exp_rspv  = 2'(1 << g);
          exp_rdata = ref_rd(int'(addr[g]));
        end
        m_last = g; pend[g] = 1'b0;
      end else begin
        if (mem_cen !== 1'b1) begin errors++; $display("FAIL rnd_idle[%0d]: got cen=%b expected 1", cyc, mem_cen); end
        exp_rspv = 2'b00;
      end
      @(posedge clk); #1;
    end
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({rspv1, rspv0} !== exp_rspv) begin errors++; $display("FAIL rnd_tail_rsp: got %b expected %b", {rspv1, rspv0}, exp_rspv); end
    @(posedge clk); #1;
  endtask

  task automatic test_init_en0;
    b_vld = 2'b01; b_wr = 2'b00; b_addr[0] = AWB'(3);
    @(negedge clk);
    checks++;
    if (b_init_done !== 1'b0 || b_rdy0 !== 1'b0 || b_cen !== 1'b1)
      begin errors++; $display("FAIL en0_in_reset: got done=%b rdy=%b cen=%b expected 0 0 1", b_init_done, b_rdy0, b_cen); end
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b_init_done !== 1'b1 || b_rdy0 !== 1'b1 || b_cen !== 1'b0 || b_mem_a !== AWB'(3))
      begin errors++; $display("FAIL en0_first_cycle: got done=%b rdy=%b cen=%b a=%0h expected 1 1 0 3", b_init_done, b_rdy0, b_cen, b_mem_a); end
    @(posedge clk); #1;
    b_vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({b_rspv1, b_rspv0} !== 2'b01) begin errors++; $display("FAIL en0_rsp_vld: got %b expected 01", {b_rspv1, b_rspv0}); end
    checks++;
    if (b_rdata !== b_preload(3)) begin errors++; $display("FAIL en0_rdata: got %h expected %h", b_rdata, b_preload(3)); end
    @(posedge clk); #1;
    b_rst = 1'b1; b_vld = 2'b01;
    @(negedge clk);
    checks++;
    if (b_rdy0 !== 1'b0 || b_cen !== 1'b1 || b_init_done !== 1'b0)
      begin errors++; $display("FAIL en0_rst_block: got rdy=%b cen=%b done=%b expected 0 1 0", b_rdy0, b_cen, b_init_done); end
    @(posedge clk); #1;
    b_rst = 1'b0; b_vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({b_rspv1, b_rspv0} !== 2'b00) begin errors++; $display("FAIL en0_no_rsp: got %b expected 00", {b_rspv1, b_rspv0}); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0; wdata[n] = '0; be[n] = '0;
      b_addr[n] = '0; b_wdata[n] = '0; b_be[n] = '0;
    end
    for (int i = 0; i < (1 << AWB); i++) sram_b[i] = b_preload(i);
    test_reset();
    test_init_abort();
    test_init_full();
    test_alternate();
    test_byte_merge();
    test_be_zero();
    test_random();
    test_init_en0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
